// File: rtl/dmem_responder.sv
// Stand-in data cache: one request at a time, fixed LATENCY, response held until acked.
// Optional write-strobe legality check enabled by defining DMEM_STRB_CHK_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [105:0] req_bus,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [31:0]  resp_rdata,
    output logic         resp_err,
    input  logic         resp_ack
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Request bus fields
    logic                  req_valid;
    logic                  req_op;
    logic [31:0]           req_addr;
    logic [3:0]            req_strb;
    logic [31:0]           req_wdata;
    logic                  req_cacop;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  unused_bits;

    assign req_valid = req_bus[105];
    assign req_op    = req_bus[104];
    assign req_addr  = req_bus[103:72];
    assign req_strb  = req_bus[70:67];
    assign req_wdata = req_bus[66:35];
    assign req_cacop = req_bus[34];
    assign req_idx   = req_addr[DEPTH_LOG2+1:2];

    // uncached, cacop_code/cacop_addr and out-of-range address bits have no effect
    assign unused_bits = ^{req_bus[71], req_bus[33:0], req_addr};

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_q;
    logic                  cacop_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [3:0]            strb_q;
    logic [31:0]           wdata_q;

    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  accept;
    logic                  commit;
    logic                  is_read;
    logic                  is_write;
    logic                  wr_reject;
    logic                  wr_en;

    logic [31:0]           mem [Words];

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CntLoad;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch, loaded only on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= 1'b0;
            cacop_q <= 1'b0;
            idx_q   <= '0;
            strb_q  <= 4'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            op_q    <= req_op;
            cacop_q <= req_cacop;
            idx_q   <= req_idx;
            strb_q  <= req_strb;
            wdata_q <= req_wdata;
        end
    end

    assign is_read  = ~op_q & ~cacop_q;
    assign is_write = op_q & ~cacop_q;

`ifdef DMEM_STRB_CHK_EN
    // Only naturally aligned byte, halfword and word strobes are legal
    always_comb begin
        wr_reject = 1'b1;
        case (strb_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: wr_reject = 1'b0;
            default:                            wr_reject = 1'b1;
        endcase
    end
`else
    assign wr_reject = 1'b0;
`endif

    assign wr_en = commit & is_write & ~wr_reject;

    // Response registers
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (commit) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = is_read ? mem[idx_q] : 32'd0;
            resp_err_d   = is_write & wr_reject;
        end else if ((state_q == StResp) && resp_ack) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM is deliberately not reset; a reset before commit leaves state_q idle, so no write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == StIdle) & ~reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded random bench for dmem_responder: directed bring-up cases, then random traffic.
module tb_dmem_responder;

    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned Words      = 2 ** DEPTH_LOG2;
    localparam int unsigned PoolSize   = 16;

`ifdef DMEM_STRB_CHK_EN
    localparam bit StrbChk = 1'b1;
`else
    localparam bit StrbChk = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [105:0] req_bus;
    logic         req_ready;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         resp_err;
    logic         resp_ack;

    int           checks;
    int           errors;
    int           cyc;
    int           ack_hold;
    exp_t         exp_q[$];
    logic [31:0]  model [Words];

    dmem_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_bus   (req_bus),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .resp_ack  (resp_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit strb_legal(input logic [3:0] s);
        return s inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                         4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Issue one request; when track is set, predict its response and update the model
    task automatic issue(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata, input logic cacop, input bit track);
        int          n;
        int          idx;
        bit          rej;
        logic [31:0] mask;
        exp_t        e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (t=%0t)", $time);
            return;
        end
        req_bus = {1'b1, op, addr, 1'($urandom()), strb, wdata, cacop,
                   2'($urandom()), 32'($urandom())};
        @(posedge clk);
        #1;
        req_bus[105] = 1'b0;
        if (track) begin
            idx  = int'((addr >> 2) % Words);
            rej  = op && !cacop && StrbChk && !strb_legal(strb);
            e.rdata   = (!op && !cacop) ? model[idx] : 32'd0;
            e.err     = rej;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            if (op && !cacop && !rej) begin
                mask = 32'd0;
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) mask = mask | (32'hFF << (8 * i));
                end
                model[idx] = (model[idx] & ~mask) | (wdata & mask);
            end
        end
    endtask

    // Monitor and consumer: pops expectations, checks held response, drives resp_ack
    initial begin
        bit   prev;
        bit   acked;
        bit   have;
        exp_t cur;
        prev     = 1'b0;
        acked    = 1'b0;
        have     = 1'b0;
        resp_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev     = 1'b0;
                acked    = 1'b0;
                have     = 1'b0;
                resp_ack = 1'b0;
            end else begin
                if (acked) begin
                    chk("valid_drop_after_ack", 32'(resp_valid), 32'd0);
                    chk("ready_after_ack", 32'(req_ready), 32'd1);
                end
                if (resp_valid) begin
                    if (!prev) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            have = 1'b0;
                            $display("FAIL unexpected_resp: got valid expected none (t=%0t)",
                                     $time);
                        end else begin
                            cur  = exp_q.pop_front();
                            have = 1'b1;
                            chk("resp_latency", 32'(cyc), 32'(cur.acc_cyc + int'(LATENCY)));
                        end
                    end
                    if (have) begin
                        chk("resp_rdata", resp_rdata, cur.rdata);
                        chk("resp_err", 32'(resp_err), 32'(cur.err));
                    end
                    chk("ready_low_in_resp", 32'(req_ready), 32'd0);
                    if (ack_hold > 0) begin
                        resp_ack = 1'b0;
                        ack_hold--;
                    end else begin
                        resp_ack = ($urandom_range(0, 3) != 0);
                    end
                end else begin
                    // stray acks outside RESP must be ignored
                    resp_ack = ($urandom_range(0, 3) == 0);
                end
                acked = resp_valid && resp_ack;
                prev  = resp_valid;
            end
        end
    end

    initial begin
        int          idx;
        int          n;
        int          r;
        logic [31:0] addr;
        checks   = 0;
        errors   = 0;
        ack_hold = 0;
        reset    = 1'b1;
        req_bus  = '0;
        for (int i = 0; i < int'(Words); i++) model[i] = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Basic write then read
        issue(1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0, 1'b1);

        // Initialise the random-test pool so every read has a known answer
        for (int i = 0; i < int'(PoolSize); i++) begin
            issue(1'b1, 32'(i << 2), 4'b1111, $urandom(), 1'b0, 1'b1);
        end

        // Byte-lane merge
        issue(1'b1, 32'h0000_0010, 4'b1111, 32'h1122_3344, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0010, 4'b0100, 32'h00AA_0000, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0, 1'b1);

        // Response held while ack is withheld
        ack_hold = 5;
        issue(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0, 1'b1);

        // Address wrap
        issue(1'b1, 32'h0000_1004, 4'b1111, 32'h5A5A_5A5A, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0004, 4'b0000, 32'h0, 1'b0, 1'b1);

        // Illegal strobe, then zero strobe, then a cacop read
        issue(1'b1, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0008, 4'b0101, 32'h1234_5678, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0008, 4'b0000, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0008, 4'b0000, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h0000_0008, 4'b0000, 32'h0, 1'b0, 1'b1);

        // Reset between accept and commit discards the write
        issue(1'b1, 32'h0000_0010, 4'b1111, 32'h0BAD_0BAD, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_rdata", resp_rdata, 32'd0);
        chk("midrst_resp_err", 32'(resp_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0, 1'b1);

        // Random traffic over the initialised pool
        for (int k = 0; k < 150; k++) begin
            idx  = $urandom_range(0, PoolSize - 1);
            addr = ($urandom() & 32'hFFFF_F003) | 32'(idx << 2);
            r    = $urandom_range(0, 9);
            if (r == 0) begin
                issue(1'($urandom()), addr, 4'($urandom()), $urandom(), 1'b1, 1'b1);
            end else if (r < 5) begin
                issue(1'b1, addr, 4'($urandom()), $urandom(), 1'b0, 1'b1);
            end else begin
                issue(1'b0, addr, 4'($urandom()), $urandom(), 1'b0, 1'b1);
            end
        end

        n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the EX/MEM data-cache request bus. It accepts one request at a time from the address-generation stage and executes it against an internal word-addressed RAM after a fixed, configurable latency. It then holds a response until the memory stage acknowledges it. It serves as the stand-in data cache for pipeline bring-up and as the far end of the request bus in unit benches.

## Interface
- `DEPTH_LOG2`, 10: RAM depth is 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, 2: number of clock edges from request acceptance to response valid. Legal values are 1..15.

- `clk`  in  1  Sole clock; all state changes on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `req_bus`  in  106  Request bus, `EXM_DCACHE_WD` wide. Fields, MSB first:
  - valid[105]
  - op[104] (0 read, 1 write)
  - addr[103:72]
  - uncached[71]
  - awstrb[70:67]
  - wdata[66:35]
  - cacop_en[34]
  - cacop_code[33:32]
  - cacop_addr[31:0]
- `req_ready`  out  1  High when a request can be accepted this cycle.
- `resp_valid`  out  1  Response pending.
- `resp_rdata`  out  32  Read data for reads; 0 for writes and cacops.
- `resp_err`  out  1  Request rejected. Qualified by `resp_valid`.
- `resp_ack`  in  1  Consumer takes the response this cycle.

## Operation
- The FSM has three states: IDLE, BUSY, RESP. Reset enters IDLE.
- `req_ready` = (state==IDLE) & ~reset.
- Acceptance happens on an edge where the FSM is in IDLE and req_bus.valid is 1. At that edge:
  - op, word index, awstrb, wdata and cacop_en are latched.
  - cnt is loaded with LATENCY-1.
  - The FSM moves to BUSY.
- Word index = addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size. addr[1:0] is ignored for reads.
- In BUSY:
  - If cnt≠0, cnt decrements and the FSM stays in BUSY.
  - If cnt==0, the commit edge occurs and the FSM moves to RESP.
- On the commit edge:
  - Read: resp_rdata ← RAM[index], the full aligned word.
  - Write: for each i with awstrb[i]=1, byte i of RAM[index] ← wdata[8i+7:8i]. resp_rdata ← 0. awstrb=0000 leaves the RAM unchanged and still produces a response.
  - cacop_en=1: no RAM access regardless of op; resp_rdata ← 0.
  - uncached and cacop_code/cacop_addr are ignored.
- In RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable.
  - When resp_ack=1, the FSM moves to IDLE and resp_valid drops.
- resp_ack outside RESP is ignored. req_bus.valid outside IDLE is ignored; the requester must hold it until it sees req_ready.
- A write followed by a read of the same index returns the written data.
- Reset mid-operation:
  - FSM returns to IDLE and cnt is cleared.
  - A latched but uncommitted write is discarded.
  - RAM contents are not cleared by reset and are undefined after power-up.

## Timing
- Reset values: req_ready=0 while reset is asserted, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0, state=IDLE.
- Call the accept edge E0. resp_valid is first high after edge E_LATENCY.
  - LATENCY=1: high the cycle right after acceptance.
  - LATENCY=2: high one cycle after that.
- The commit edge is E_LATENCY.
- Minimum throughput is one request per LATENCY+2 cycles: accept, LATENCY cycles, ack cycle, then IDLE. The same edge never both acks and accepts.
- `req_ready` depends only on state and reset, with no combinational path from req_bus. resp_* are registered.

## Configuration
- Macro `DMEM_STRB_CHK_EN`.
- Defined:
  - A write whose awstrb is not in {0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111} is rejected.
  - On the commit edge a rejected write sets resp_err=1, leaves the RAM unchanged and sets resp_rdata=0.
  - Reads and cacops always have resp_err=0.
- Not defined: every strobe pattern is written byte-wise and resp_err is tied to 0.

## Test plan
- Reset, then write addr 0x0000_0010, awstrb 1111, wdata 0xDEADBEEF; ack; read 0x10. Required: resp_rdata=0xDEADBEEF, with resp_valid exactly LATENCY edges after each accept.
- Preload 0x11223344 at index 4, write awstrb 0100 with wdata 0x00AA0000, read index 4. Required: 0x11AA3344.
- Hold resp_ack=0 for 5 cycles in RESP. Required: resp_valid, resp_rdata stable and req_ready=0 throughout. On ack, IDLE next edge and req_ready=1.
- DEPTH_LOG2=10, write 0x5A5A5A5A to addr 0x0000_1004, read addr 0x4. Required: 0x5A5A5A5A (wrap).
- Accept a write, assert reset before the commit edge, then read the same address. Required: old contents; all outputs 0 during reset.
- With DMEM_STRB_CHK_EN, write awstrb 0101. Required: resp_err=1 and RAM unchanged. Without the macro, resp_err=0 and bytes 0 and 2 are written.
